// File: rtl/hwce_engine_ctrl_fsm.sv
// HWCE convolution engine control FSM: line-buffer preload, overlapped
// weight load, streaming run and automatic output-group looping.
module hwce_engine_ctrl_fsm #(
  parameter int LINEBUF_W_MAX = 64,
  parameter int FS_MAX        = 7,
  parameter int OG_W          = 8,
  parameter int CNT_W = $clog2(LINEBUF_W_MAX*(FS_MAX-1)+FS_MAX)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clear,
  input  logic            engine_start,
  input  logic [15:0]     linebuf_length,
  input  logic [2:0]      filter_size,
  input  logic [2:0]      zero_padding_i,
  input  logic [OG_W-1:0] n_og_i,
  input  logic            x_in_valid,
  input  logic            x_in_ready,
  input  logic            x_in_feat_update,
  input  logic            y_out_feat_update,
  input  logic            weight_done,
  output logic            weight_start,
  output logic            hold_o,
  output logic            sop_clear,
  output logic [OG_W-1:0] n_og_o,
  output logic [3:0]      fsm_state_o,
  output logic            busy_o,
  output logic            done_o,
  output logic            exception_o
);

  typedef enum logic [3:0] {
    IDLE    = 4'b0000,
    PLWL    = 4'b1001,
    PRELOAD = 4'b0001,
    WAITW   = 4'b0101,
    RUN     = 4'b0011,
    CHG     = 4'b0010,
    TERM    = 4'b0110,
    ERR     = 4'b1111
  } state_t;

  state_t          state;
  logic [CNT_W-1:0] cnt;
  logic [OG_W-1:0] og_cnt;
  logic [15:0]     len_q;
  logic [2:0]      k_q;
  logic [1:0]      zp_q;
  logic [OG_W-1:0] n_og_q;

  logic            hs;
  logic            fill;
  logic            k_legal;
  logic            last_og;
  logic [31:0]     k_m1;
  logic [31:0]     pad;
  logic [31:0]     rows;
  logic [31:0]     cols;
  logic [31:0]     thr;
  logic [OG_W:0]   nxt_og;
  logic [OG_W-1:0] n_eff;
  logic            unused_nb;

  // bottom-padding flag does not affect the preload depth
  assign unused_nb = zero_padding_i[2];

  assign hs      = x_in_valid & x_in_ready;
  assign k_legal = filter_size[0];

  always_comb begin
    k_m1 = 32'(k_q) - 32'd1;
    pad  = k_m1 >> 1;
    rows = (zp_q[0] & ~zp_q[1]) ? k_m1 - pad : k_m1;
    cols = zp_q[0] ? k_m1 - pad : k_m1;
    thr  = 32'(len_q) * rows + cols;
  end

  assign fill    = hs & (32'(cnt) == thr);
  assign n_eff   = (n_og_q == '0) ? OG_W'(1) : n_og_q;
  assign nxt_og  = {1'b0, og_cnt} + (OG_W+1)'(1);
  assign last_og = nxt_og >= {1'b0, n_eff};

  assign fsm_state_o = state;
  assign busy_o      = state != IDLE;
  assign hold_o      = state == WAITW;
  assign n_og_o      = og_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      og_cnt       <= '0;
      len_q        <= '0;
      k_q          <= '0;
      zp_q         <= '0;
      n_og_q       <= '0;
      weight_start <= 1'b0;
      sop_clear    <= 1'b1;
      done_o       <= 1'b0;
      exception_o  <= 1'b0;
    end else if (clear) begin
      state        <= IDLE;
      cnt          <= '0;
      weight_start <= 1'b0;
      sop_clear    <= 1'b1;
      done_o       <= 1'b0;
      exception_o  <= 1'b0;
    end else begin
      weight_start <= 1'b0;
      done_o       <= 1'b0;
      if (state == PLWL || state == PRELOAD)
        cnt <= cnt + CNT_W'(hs);
      else
        cnt <= '0;
      case (state)
        IDLE: if (engine_start) begin
          if (k_legal) begin
            len_q        <= linebuf_length;
            k_q          <= filter_size;
            zp_q         <= zero_padding_i[1:0];
            n_og_q       <= n_og_i;
            og_cnt       <= '0;
            weight_start <= 1'b1;
            state        <= PLWL;
            sop_clear    <= 1'b1;
          end else begin
            exception_o <= 1'b1;
            state       <= ERR;
            sop_clear   <= 1'b1;
          end
        end
        PLWL: begin
          if (fill && weight_done) begin
            state     <= RUN;
            sop_clear <= 1'b0;
          end else if (fill) begin
            state     <= WAITW;
            sop_clear <= 1'b1;
          end else if (weight_done) begin
            state     <= PRELOAD;
            sop_clear <= 1'b0;
          end
        end
        PRELOAD: if (fill) begin
          state     <= RUN;
          sop_clear <= 1'b0;
        end
        WAITW: if (weight_done) begin
          state     <= RUN;
          sop_clear <= 1'b0;
        end
        RUN: if (x_in_feat_update && x_in_ready) begin
          state     <= last_og ? TERM : CHG;
          sop_clear <= 1'b0;
        end
        CHG: if (y_out_feat_update) begin
          og_cnt       <= og_cnt + OG_W'(1);
          weight_start <= 1'b1;
          state        <= PLWL;
          sop_clear    <= 1'b1;
        end
        TERM: if (y_out_feat_update) begin
          done_o    <= 1'b1;
          state     <= IDLE;
          sop_clear <= 1'b1;
        end
        ERR: ;
        default: begin
          state     <= IDLE;
          sop_clear <= 1'b1;
        end
      endcase
    end
  end

endmodule
